// File: rtl/hex_marquee_pkg.sv
// hex_marquee shared definitions.
// Segment glyphs (active-low, bit6=a .. bit0=g) and scroll direction.
package hex_marquee_pkg;

    localparam int SEG_BITS = 7;

    localparam logic [SEG_BITS-1:0] SEG_H     = 7'b1001000;
    localparam logic [SEG_BITS-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_BITS-1:0] SEG_L     = 7'b1110001;
    localparam logic [SEG_BITS-1:0] SEG_O     = 7'b0000001;
    localparam logic [SEG_BITS-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    function automatic logic [SEG_BITS-1:0] reset_seg(input int i);
        case (i)
            4:       reset_seg = SEG_H;
            3:       reset_seg = SEG_E;
            2:       reset_seg = SEG_L;
            1:       reset_seg = SEG_L;
            0:       reset_seg = SEG_O;
            default: reset_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/hex_marquee_if.sv
// hex_marquee control/display bundle.
// master drives keys, mode and load port; slave drives the display.
interface hex_marquee_if #(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 7
) ();

    localparam int IW = $clog2(NUM_DIGITS);

    logic                        key_dir_n;
    logic                        key_pause_n;
    logic                        bounce_en;
    logic [1:0]                  speed;
    logic                        load_en;
    logic [IW-1:0]               load_idx;
    logic [SEG_W-1:0]            load_seg;
    logic [NUM_DIGITS*SEG_W-1:0] seg_out;
    logic                        shift_o;
    logic                        dir_o;

    modport master (
        output key_dir_n, key_pause_n, bounce_en, speed,
        output load_en, load_idx, load_seg,
        input  seg_out, shift_o, dir_o
    );

    modport slave (
        input  key_dir_n, key_pause_n, bounce_en, speed,
        input  load_en, load_idx, load_seg,
        output seg_out, shift_o, dir_o
    );

endinterface

// File: rtl/hex_marquee_tick.sv
// hex_tick_gen: shift prescaler, divisor max(1, TICK_DIV >> speed).
// Uses >= so a speed change that strands cnt past the end ticks at once.
module hex_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CW = $clog2(TICK_DIV + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;

    always_comb begin
        div = CW'(TICK_DIV >> speed);
        if (div == '0) div = CW'(1);
    end

    assign tick = (cnt >= div - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/hex_marquee.sv
// hex_marquee: N-digit 7-segment scrolling ring with key sync,
// speed select, ping-pong mode and per-digit load port.
module hex_marquee
    import hex_marquee_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 7,
    parameter int TICK_DIV   = 12_500_000
) (
    input logic         clk,
    input logic         rst,
    hex_marquee_if.slave bus
);

    localparam int IW = $clog2(NUM_DIGITS);

    if (NUM_DIGITS < 5) begin : g_bad_digits
        $error("hex_marquee: NUM_DIGITS must be >= 5");
    end
    if (SEG_W != SEG_BITS) begin : g_bad_segw
        $error("hex_marquee: SEG_W must be 7");
    end

    logic [1:0] dsync;
    logic [1:0] psync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsync <= 2'b11;
            psync <= 2'b11;
        end else begin
            dsync <= {dsync[0], bus.key_dir_n};
            psync <= {psync[0], bus.key_pause_n};
        end
    end

    logic key_dir;
    logic pause;

    assign key_dir = ~dsync[1];
    assign pause   = ~psync[1];

    logic tick;

    hex_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .speed(bus.speed),
        .tick (tick)
    );

    logic load_ok;
    logic do_shift;
    dir_t dir_cur;

    dir_t          bdir;
    dir_t          bdir_nx;
    logic [IW-1:0] step;
    logic [IW-1:0] step_nx;

    assign load_ok  = bus.load_en && (int'(bus.load_idx) < NUM_DIGITS);
    assign do_shift = tick && !load_ok && !pause;
    assign dir_cur  = bus.bounce_en ? bdir : (key_dir ? DIR_R : DIR_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bdir <= DIR_L;
            step <= '0;
        end else begin
            bdir <= bdir_nx;
            step <= step_nx;
        end
    end

    // Ping-pong turns around on the shift that completes N-1 steps.
    always_comb begin
        bdir_nx = bdir;
        step_nx = step;
        if (!bus.bounce_en) begin
            bdir_nx = DIR_L;
            step_nx = '0;
        end else if (do_shift) begin
            if (step == IW'(NUM_DIGITS - 2)) begin
                step_nx = '0;
                bdir_nx = (bdir == DIR_L) ? DIR_R : DIR_L;
            end else begin
                step_nx = step + IW'(1);
            end
        end
    end

    logic [SEG_W-1:0] ring [NUM_DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                ring[i] <= reset_seg(i);
        end else if (load_ok) begin
            ring[bus.load_idx] <= bus.load_seg;
        end else if (do_shift) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dir_cur == DIR_L)
                    ring[i] <= ring[(i + NUM_DIGITS - 1) % NUM_DIGITS];
                else
                    ring[i] <= ring[(i + 1) % NUM_DIGITS];
            end
        end
    end

    logic shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shift_q <= 1'b0;
        else     shift_q <= do_shift;
    end

    logic [NUM_DIGITS*SEG_W-1:0] seg_flat;

    always_comb begin
        seg_flat = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            seg_flat[i*SEG_W +: SEG_W] = ring[i];
    end

    assign bus.seg_out = seg_flat;
    assign bus.shift_o = shift_q;
    assign bus.dir_o   = (dir_cur == DIR_R);

endmodule

// File: tb/tb_hex_marquee.sv
// tb_hex_marquee: scenario tasks plus randomized run against a
// rotating-array reference model (N=8, TICK_DIV=4) and an N=6 load check.
module tb_hex_marquee;

    localparam int N  = 8;
    localparam int N6 = 6;

    localparam logic [6:0] GH = 7'b1001000;
    localparam logic [6:0] GE = 7'b0110000;
    localparam logic [6:0] GL = 7'b1110001;
    localparam logic [6:0] GO = 7'b0000001;
    localparam logic [6:0] GB = 7'b1111111;

    localparam logic [N*7-1:0]  RST8 = {GB, GB, GB, GH, GE, GL, GL, GO};
    localparam logic [N6*7-1:0] RST6 = {GB, GH, GE, GL, GL, GO};
    localparam logic [N*7-1:0]  EXPL = {GB, GB, GH, GE, GL, GL, GO, GB};
    localparam logic [N*7-1:0]  EXPR = {GO, GB, GB, GB, GH, GE, GL, GL};
    localparam logic [N*7-1:0]  EXPLD = {GO, GB, GB, GH, GE, GL, GL, GO};

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hex_marquee_if #(.NUM_DIGITS(N),  .SEG_W(7)) mif ();
    hex_marquee_if #(.NUM_DIGITS(N6), .SEG_W(7)) sif ();

    hex_marquee #(
        .NUM_DIGITS(N), .SEG_W(7), .TICK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(mif.slave)
    );

    hex_marquee #(
        .NUM_DIGITS(N6), .SEG_W(7), .TICK_DIV(4)
    ) dut6 (
        .clk(clk), .rst(rst), .bus(sif.slave)
    );

    int npass = 0;
    int ntot  = 0;

    logic [6:0] m [N];
    int   ecnt;
    int   bshifts;
    int   div_m;
    logic kd0, kd1, kp0, kp1;
    logic exp_shift;

    function automatic logic [N*7-1:0] flat();
        logic [N*7-1:0] f;
        for (int i = 0; i < N; i++) f[i*7 +: 7] = m[i];
        return f;
    endfunction

    function automatic logic exp_dir();
        if (mif.bounce_en) return ((bshifts / (N - 1)) % 2) == 1;
        return kd1;
    endfunction

    task automatic model_reset();
        logic [N*7-1:0] r;
        r = RST8;
        for (int i = 0; i < N; i++) m[i] = r[i*7 +: 7];
        ecnt      = 0;
        bshifts   = 0;
        kd0 = 1'b0; kd1 = 1'b0;
        kp0 = 1'b0; kp1 = 1'b0;
        exp_shift = 1'b0;
        div_m     = 4 >> mif.speed;
        if (div_m < 1) div_m = 1;
    endtask

    task automatic reset_on();
        rst = 1'b1;
        #2;
    endtask

    task automatic reset_off();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock edge: advance the reference model with the inputs seen there.
    task automatic cyc();
        logic tk, ld, pz, dr, dir;
        logic [6:0] t;
        @(posedge clk);
        tk = (ecnt % div_m) == (div_m - 1);
        ecnt++;
        ld = mif.load_en && (int'(mif.load_idx) < N);
        pz = kp1;
        dr = kd1;
        kp1 = kp0; kp0 = !mif.key_pause_n;
        kd1 = kd0; kd0 = !mif.key_dir_n;
        dir = mif.bounce_en ? (((bshifts / (N - 1)) % 2) == 1) : dr;
        exp_shift = tk && !ld && !pz;
        if (ld) begin
            m[mif.load_idx] = mif.load_seg;
        end else if (exp_shift) begin
            if (!dir) begin
                t = m[N-1];
                for (int i = N - 1; i > 0; i--) m[i] = m[i-1];
                m[0] = t;
            end else begin
                t = m[0];
                for (int i = 0; i < N - 1; i++) m[i] = m[i+1];
                m[N-1] = t;
            end
        end
        if (!mif.bounce_en) bshifts = 0;
        else if (exp_shift) bshifts++;
        #1;
    endtask

    task automatic defaults();
        mif.key_dir_n   = 1'b1;
        mif.key_pause_n = 1'b1;
        mif.bounce_en   = 1'b0;
        mif.speed       = 2'd0;
        mif.load_en     = 1'b0;
        mif.load_idx    = '0;
        mif.load_seg    = '0;
    endtask

    task automatic test_reset();
        #12;
        ntot++;
        if (mif.seg_out !== RST8)
            $display("FAIL reset_seg got=%h want=%h", mif.seg_out, RST8);
        else npass++;
        ntot++;
        if (mif.shift_o !== 1'b0 || mif.dir_o !== 1'b0)
            $display("FAIL reset_flags got=%b%b want=00", mif.shift_o, mif.dir_o);
        else npass++;
        ntot++;
        if (sif.seg_out !== RST6)
            $display("FAIL reset_seg6 got=%h want=%h", sif.seg_out, RST6);
        else npass++;
    endtask

    task automatic test_first_shift();
        reset_off();
        repeat (3) cyc();
        ntot++;
        if (mif.shift_o !== 1'b0 || mif.seg_out !== RST8)
            $display("FAIL early_shift got=%b %h want=0 %h", mif.shift_o, mif.seg_out, RST8);
        else npass++;
        cyc();
        ntot++;
        if (mif.seg_out !== EXPL)
            $display("FAIL first_left got=%h want=%h", mif.seg_out, EXPL);
        else npass++;
        ntot++;
        if (mif.shift_o !== 1'b1)
            $display("FAIL first_strobe got=%b want=1", mif.shift_o);
        else npass++;
        cyc();
        ntot++;
        if (mif.shift_o !== 1'b0)
            $display("FAIL strobe_width got=%b want=0", mif.shift_o);
        else npass++;
    endtask

    task automatic test_dir_key();
        reset_on();
        mif.key_dir_n = 1'b0;
        reset_off();
        repeat (4) cyc();
        ntot++;
        if (mif.seg_out !== EXPR)
            $display("FAIL first_right got=%h want=%h", mif.seg_out, EXPR);
        else npass++;
        ntot++;
        if (mif.dir_o !== 1'b1)
            $display("FAIL dir_key got=%b want=1", mif.dir_o);
        else npass++;
        mif.key_dir_n = 1'b1;
    endtask

    task automatic test_pause();
        int n;
        reset_on();
        mif.key_pause_n = 1'b0;
        reset_off();
        for (int k = 0; k < 12; k++) begin
            cyc();
            ntot++;
            if (mif.shift_o !== 1'b0 || mif.seg_out !== RST8)
                $display("FAIL pause_hold c=%0d got=%b %h want=0 %h",
                         k, mif.shift_o, mif.seg_out, RST8);
            else npass++;
        end
        mif.key_pause_n = 1'b1;
        n = 0;
        while (n < 10 && mif.shift_o !== 1'b1) begin
            cyc();
            n++;
        end
        ntot++;
        if (n != 4 || mif.seg_out !== EXPL)
            $display("FAIL pause_resume got=%0d %h want=4 %h", n, mif.seg_out, EXPL);
        else npass++;
    endtask

    task automatic test_bounce();
        int ns;
        reset_on();
        mif.bounce_en = 1'b1;
        mif.key_dir_n = 1'b0;
        reset_off();
        ns = 0;
        repeat (28) begin
            cyc();
            if (mif.shift_o === 1'b1) ns++;
        end
        ntot++;
        if (ns != 7 || mif.dir_o !== 1'b1)
            $display("FAIL bounce_turn got=%0d/%b want=7/1", ns, mif.dir_o);
        else npass++;
        ntot++;
        if (mif.seg_out !== flat())
            $display("FAIL bounce_left got=%h want=%h", mif.seg_out, flat());
        else npass++;
        repeat (28) cyc();
        ntot++;
        if (mif.seg_out !== RST8 || mif.dir_o !== 1'b0)
            $display("FAIL bounce_back got=%h/%b want=%h/0", mif.seg_out, mif.dir_o, RST8);
        else npass++;
        mif.bounce_en = 1'b0;
        cyc();
        ntot++;
        if (mif.dir_o !== 1'b1)
            $display("FAIL bounce_off got=%b want=1", mif.dir_o);
        else npass++;
        mif.key_dir_n = 1'b1;
    endtask

    task automatic test_load();
        reset_on();
        sif.key_pause_n = 1'b0;
        reset_off();
        sif.load_en  = 1'b1;
        sif.load_seg = 7'b0000000;
        sif.load_idx = 3'd6;
        repeat (3) cyc();
        mif.load_en  = 1'b1;
        mif.load_idx = 3'd7;
        mif.load_seg = GO;
        sif.load_idx = 3'd7;
        cyc();
        mif.load_en  = 1'b0;
        ntot++;
        if (mif.shift_o !== 1'b0 || mif.seg_out !== EXPLD)
            $display("FAIL load_tick got=%b %h want=0 %h", mif.shift_o, mif.seg_out, EXPLD);
        else npass++;
        ntot++;
        if (sif.seg_out !== RST6)
            $display("FAIL load_bad_idx got=%h want=%h", sif.seg_out, RST6);
        else npass++;
        sif.load_idx = 3'd5;
        cyc();
        sif.load_en = 1'b0;
        repeat (4) cyc();
        ntot++;
        if (sif.seg_out !== {7'b0000000, RST6[34:0]})
            $display("FAIL load_idx5 got=%h want=%h", sif.seg_out, {7'b0000000, RST6[34:0]});
        else npass++;
        ntot++;
        if (mif.seg_out !== flat())
            $display("FAIL load_then_shift got=%h want=%h", mif.seg_out, flat());
        else npass++;
        sif.key_pause_n = 1'b1;
    endtask

    task automatic test_speed();
        reset_on();
        mif.speed = 2'd3;
        reset_off();
        for (int k = 0; k < 5; k++) begin
            cyc();
            ntot++;
            if (mif.shift_o !== 1'b1 || mif.seg_out !== flat())
                $display("FAIL speed_fast c=%0d got=%b %h want=1 %h",
                         k, mif.shift_o, mif.seg_out, flat());
            else npass++;
        end
        reset_on();
        mif.speed = 2'd0;
        reset_off();
        repeat (2) cyc();
        mif.speed = 2'd1;
        @(posedge clk);
        #1;
        ntot++;
        if (mif.shift_o !== 1'b1 || mif.seg_out !== EXPL)
            $display("FAIL speed_force got=%b %h want=1 %h", mif.shift_o, mif.seg_out, EXPL);
        else npass++;
        mif.speed = 2'd0;
    endtask

    task automatic test_random();
        reset_on();
        reset_off();
        for (int k = 0; k < 400; k++) begin
            mif.load_en  = ($urandom % 4) == 0;
            mif.load_idx = 3'($urandom_range(0, 7));
            mif.load_seg = 7'($urandom);
            if (($urandom % 12) == 0) mif.key_dir_n   = ~mif.key_dir_n;
            if (($urandom % 16) == 0) mif.key_pause_n = ~mif.key_pause_n;
            if (($urandom % 40) == 0) mif.bounce_en   = ~mif.bounce_en;
            cyc();
            ntot++;
            if (mif.seg_out !== flat() || mif.shift_o !== exp_shift || mif.dir_o !== exp_dir())
                $display("FAIL random c=%0d got=%h/%b/%b want=%h/%b/%b", k,
                         mif.seg_out, mif.shift_o, mif.dir_o, flat(), exp_shift, exp_dir());
            else npass++;
        end
        defaults();
    endtask

    task automatic test_reset_mid();
        int n;
        reset_on();
        reset_off();
        repeat (8) cyc();
        #3;
        rst = 1'b1;
        #1;
        ntot++;
        if (mif.seg_out !== RST8 || mif.shift_o !== 1'b0 || mif.dir_o !== 1'b0)
            $display("FAIL reset_async got=%h/%b/%b want=%h/0/0",
                     mif.seg_out, mif.shift_o, mif.dir_o, RST8);
        else npass++;
        reset_off();
        n = 0;
        while (n < 10 && mif.shift_o !== 1'b1) begin
            cyc();
            n++;
        end
        ntot++;
        if (n != 4)
            $display("FAIL reset_cnt got=%0d want=4", n);
        else npass++;
    endtask

    initial begin
        defaults();
        sif.key_dir_n   = 1'b1;
        sif.key_pause_n = 1'b1;
        sif.bounce_en   = 1'b0;
        sif.speed       = 2'd0;
        sif.load_en     = 1'b0;
        sif.load_idx    = '0;
        sif.load_seg    = '0;
        test_reset();
        test_first_shift();
        test_dir_key();
        test_pause();
        test_bounce();
        test_load();
        test_speed();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
